// File: rtl/crack_sched_pkg.sv
// Shared definitions for the RC4 key-search scheduler.
//   KEY_W    : width of an RC4 key in the search space
//   state_t  : scheduler FSM states
//   outst_w  : width of the outstanding-chunk counter; sized for every chunk
//              of the key space being in flight at once, plus the zero state.
package crack_sched_pkg;

   localparam int KEY_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      DRAIN,
      DONE_OK,
      DONE_FAIL
   } state_t;

   function automatic int outst_w(input int key_max, input int chunk_log2);
      int chunks;
      chunks = (key_max >> chunk_log2) + 1;
      return (chunks < 1) ? 1 : $clog2(chunks + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   mask  : requesters excluded this cycle
//   ptr   : index with highest priority this cycle
//   gnt   : one-hot grant (all zero when nothing eligible)
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic [N-1:0]     eligible;
   logic [PTR_W-1:0] idx;
   logic             hit;

   assign eligible = req & ~mask;

   // Scan from ptr upwards, wrapping; first eligible index wins.
   always_comb begin
      gnt = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (!hit && eligible[idx]) begin
            gnt[idx] = 1'b1;
            hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/crack_scheduler.sv
// Hands out consecutive key chunks to a pool of RC4 cracking cores, tracks
// chunks in flight, and reports the first hit or exhaustion of the key space.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : pulse that begins a search (ignored while busy)
//   core_req       : per-core chunk request, held until granted
//   core_done      : per-core pulse, chunk exhausted without a hit
//   core_found     : per-core pulse, valid message decrypted
//   core_key       : per-core winning key, slice i belongs to core i
//   core_grant     : one-hot grant pulse, grant_base is the chunk's first key
//   core_abort     : pulse telling all cores to stop
//   busy           : search in progress (DISPATCH or DRAIN)
//   secret_key     : cracked key, cracked / failed are sticky result flags
module crack_scheduler
   import crack_sched_pkg::*;
#(
   parameter int               NUM_CORES  = 4,
   parameter int               CHUNK_LOG2 = 16,
   parameter logic [KEY_W-1:0] KEY_MAX    = 24'h3FFFFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NUM_CORES-1:0]       core_req,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES-1:0]       core_found,
   input  logic [KEY_W*NUM_CORES-1:0] core_key,
   output logic [NUM_CORES-1:0]       core_grant,
   output logic [KEY_W-1:0]           grant_base,
   output logic                       core_abort,
   output logic                       busy,
   output logic [KEY_W-1:0]           secret_key,
   output logic                       cracked,
   output logic                       failed
);

   localparam int             PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int             OUT_W = outst_w(int'(KEY_MAX), CHUNK_LOG2);
   localparam logic [KEY_W:0] CHUNK = (KEY_W + 1)'(1) << CHUNK_LOG2;

   state_t               state;
   // One bit wider than a key so the pointer can step past KEY_MAX.
   logic [KEY_W:0]       next_base;
   logic [OUT_W-1:0]     outstanding;
   logic [PTR_W-1:0]     rr_ptr;

   logic [NUM_CORES-1:0] arb_gnt;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W-1:0]     ptr_nxt;
   logic [OUT_W-1:0]     done_cnt;
   logic [OUT_W-1:0]     out_nxt;
   logic [KEY_W-1:0]     found_key;
   logic                 any_found;
   logic                 space_left;
   logic                 grant_fire;

   // Last cycle's grant is masked so a still-held request is not served twice.
   rr_arbiter #(
      .N     (NUM_CORES),
      .PTR_W (PTR_W)
   ) u_arb (
      .req  (core_req),
      .mask (core_grant),
      .ptr  (rr_ptr),
      .gnt  (arb_gnt)
   );

   assign busy       = (state == DISPATCH) || (state == DRAIN);
   assign any_found  = |core_found;
   assign space_left = (next_base <= {1'b0, KEY_MAX});
   // A hit pre-empts any grant in the same cycle.
   assign grant_fire = (state == DISPATCH) && space_left && !any_found && |arb_gnt;

   always_comb begin
      gnt_idx   = '0;
      done_cnt  = '0;
      found_key = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (arb_gnt[i]) gnt_idx = PTR_W'(i);
         done_cnt = done_cnt + OUT_W'(core_done[i]);
      end
      // Descending scan leaves the lowest-index hit in found_key.
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_found[i]) found_key = core_key[i*KEY_W +: KEY_W];
      end
   end

   assign ptr_nxt = (int'(gnt_idx) == NUM_CORES - 1) ? '0 : gnt_idx + PTR_W'(1);
   assign out_nxt = outstanding + OUT_W'(grant_fire) - done_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         next_base   <= '0;
         outstanding <= '0;
         rr_ptr      <= '0;
         core_grant  <= '0;
         grant_base  <= '0;
         core_abort  <= 1'b0;
         secret_key  <= '0;
         cracked     <= 1'b0;
         failed      <= 1'b0;
      end else begin
         core_grant <= '0;
         core_abort <= 1'b0;
         case (state)
            IDLE, DONE_OK, DONE_FAIL: begin
               if (start) begin
                  state       <= DISPATCH;
                  next_base   <= '0;
                  outstanding <= '0;
                  rr_ptr      <= '0;
                  secret_key  <= '0;
                  cracked     <= 1'b0;
                  failed      <= 1'b0;
               end
            end
            DISPATCH, DRAIN: begin
               if (any_found) begin
                  state       <= DONE_OK;
                  secret_key  <= found_key;
                  cracked     <= 1'b1;
                  core_abort  <= 1'b1;
                  outstanding <= out_nxt;
               end else begin
                  outstanding <= out_nxt;
                  if (state == DISPATCH) begin
                     if (!space_left) begin
                        state <= DRAIN;
                     end else if (grant_fire) begin
                        core_grant <= arb_gnt;
                        grant_base <= next_base[KEY_W-1:0];
                        next_base  <= next_base + CHUNK;
                        rr_ptr     <= ptr_nxt;
                     end
                  end else if (out_nxt == '0) begin
                     state  <= DONE_FAIL;
                     failed <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler with 4 cores and 1M-key chunks, so the
// default key space splits into exactly four chunks.
module tb_crack_scheduler;
   import crack_sched_pkg::*;

   localparam int NC = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [NC-1:0]     core_req = '0;
   logic [NC-1:0]     core_done = '0;
   logic [NC-1:0]     core_found = '0;
   logic [KEY_W*NC-1:0] core_key = '0;
   logic [NC-1:0]     core_grant;
   logic [KEY_W-1:0]  grant_base;
   logic              core_abort;
   logic              busy;
   logic [KEY_W-1:0]  secret_key;
   logic              cracked;
   logic              failed;

   int checks = 0;
   int errors = 0;

   crack_scheduler #(
      .NUM_CORES  (NC),
      .CHUNK_LOG2 (20),
      .KEY_MAX    (24'h3FFFFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .core_req   (core_req),
      .core_done  (core_done),
      .core_found (core_found),
      .core_key   (core_key),
      .core_grant (core_grant),
      .grant_base (grant_base),
      .core_abort (core_abort),
      .busy       (busy),
      .secret_key (secret_key),
      .cracked    (cracked),
      .failed     (failed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // All four cores request; expect cores 0..3 served with bases 0..3 MB.
   task automatic run_grants();
      core_req = 4'b1111;
      for (int i = 0; i < NC; i++) begin
         step();
         chk("grant_onehot", 32'(core_grant), 32'(1 << i));
         chk("grant_base", 32'(grant_base), 32'(i) << 20);
         core_req = core_req & ~core_grant;
      end
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_grant", 32'(core_grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", {30'b0, cracked, failed}, 0);
      reset = 1'b0;

      // Exhaustion: four chunks, four dones, no hit
      pulse_start();
      chk("busy_after_start", 32'(busy), 1);
      run_grants();
      step();
      chk("drain_no_grant", 32'(core_grant), 0);
      chk("drain_busy", 32'(busy), 1);
      for (int i = 0; i < NC; i++) begin
         chk("failed_pre", 32'(failed), 0);
         core_done = 4'(1 << i);
         step();
      end
      core_done = '0;
      chk("failed_set", 32'(failed), 1);
      chk("fail_not_cracked", 32'(cracked), 0);
      chk("fail_idle", 32'(busy), 0);

      // Single hit on core 2 during DISPATCH
      pulse_start();
      chk("restart_clears_failed", 32'(failed), 0);
      core_req = 4'b1111;
      step();
      chk("hit_first_grant", 32'(core_grant), 32'h1);
      core_req = 4'b1110;
      core_found = 4'b0100;
      core_key[2*KEY_W +: KEY_W] = 24'h1A2B3C;
      step();
      core_found = '0;
      chk("hit_key", 32'(secret_key), 32'h1A2B3C);
      chk("hit_cracked", 32'(cracked), 1);
      chk("hit_abort", 32'(core_abort), 1);
      chk("hit_no_grant", 32'(core_grant), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_once", 32'(core_abort), 0);
         chk("no_grant_after_hit", 32'(core_grant), 0);
      end
      core_req = '0;

      // Two hits same cycle: lowest index wins
      pulse_start();
      core_found = 4'b1010;
      core_key[1*KEY_W +: KEY_W] = 24'h000111;
      core_key[3*KEY_W +: KEY_W] = 24'h000333;
      step();
      core_found = '0;
      chk("dual_hit_key", 32'(secret_key), 32'h000111);
      chk("dual_hit_cracked", 32'(cracked), 1);

      // Last done and a hit on core 0 in the same cycle
      pulse_start();
      run_grants();
      step();
      core_done = 4'b1110;
      step();
      chk("multi_done_still_busy", 32'(busy), 1);
      core_done = 4'b0001;
      core_found = 4'b0001;
      core_key[0 +: KEY_W] = 24'h00ABCD;
      step();
      core_done = '0;
      core_found = '0;
      chk("race_cracked", 32'(cracked), 1);
      chk("race_failed", 32'(failed), 0);
      chk("race_key", 32'(secret_key), 32'h00ABCD);

      // Asynchronous reset mid-DISPATCH with three chunks out
      pulse_start();
      core_req = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         step();
         core_req = core_req & ~core_grant;
      end
      chk("pre_rst_grant", 32'(core_grant), 32'h4);
      reset = 1'b1;
      #1;
      chk("async_rst_grant", 32'(core_grant), 0);
      chk("async_rst_base", 32'(grant_base), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_flags", {31'b0, core_abort}, 0);
      reset = 1'b0;
      core_req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("no_grant_before_start", 32'(core_grant), 0);
      end

      // Restart, then a start pulse while busy must be ignored
      pulse_start();
      step();
      chk("restart_base", 32'(grant_base), 0);
      chk("restart_grant", 32'(core_grant), 32'h1);
      core_req = 4'b1110;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_start_base", 32'(grant_base), 32'h100000);
      chk("busy_start_grant", 32'(core_grant), 32'h2);
      core_req = 4'b1100;
      step();
      chk("post_base2", 32'(grant_base), 32'h200000);
      core_req = 4'b1000;
      step();
      chk("post_base3", 32'(grant_base), 32'h300000);
      core_req = '0;
      step();
      core_done = 4'b1111;
      step();
      core_done = '0;
      chk("all_done_failed", 32'(failed), 1);
      chk("all_done_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/crack_scheduler.md
CRACK_SCHEDULER -- requirements
Module: crack_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: number of RC4 cracking cores served.
REQ-002 Parameter CHUNK_LOG2, default 16: each chunk holds 2^CHUNK_LOG2 consecutive keys.
REQ-003 Parameter KEY_MAX, default 24'h3FFFFF: last key in the search space.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a search.
REQ-007 core_req  in  NUM_CORES  core i requests a chunk; held until granted.
REQ-008 core_done  in  NUM_CORES  one-cycle pulse: core i exhausted its chunk with no hit.
REQ-009 core_found  in  NUM_CORES  one-cycle pulse: core i decrypted a valid message.
REQ-010 core_key  in  24*NUM_CORES  winning key of core i (slice i), valid with core_found[i].
REQ-011 core_grant  out  NUM_CORES  one-hot, one-cycle pulse granting a chunk.
REQ-012 grant_base  out  24  first key of the granted chunk, valid with core_grant.
REQ-013 core_abort  out  1  one-cycle pulse commanding all cores to stop.
REQ-014 busy  out  1  high in DISPATCH and DRAIN.
REQ-015 secret_key  out  24  cracked key; held until next start.
REQ-016 cracked / failed  out  1 each  sticky result flags.

Function
REQ-017 States SHALL be IDLE, DISPATCH, DRAIN, DONE_OK, DONE_FAIL.
REQ-018 IDLE/DONE_OK/DONE_FAIL + start: next_base=0, outstanding=0, cracked=failed=0, secret_key=0, rr pointer=0 -> DISPATCH.
REQ-019 start while busy SHALL be ignored.
REQ-020 DISPATCH: each cycle at most one requester is chosen by round-robin, starting at index (last granted + 1) mod NUM_CORES.
REQ-021 Grant SHALL be registered: core_grant and grant_base appear the cycle after the request is sampled, and next_base advances by 2^CHUNK_LOG2.
REQ-022 A core granted in cycle t SHALL be masked from arbitration in cycle t+1, so a held request is not granted twice.
REQ-023 next_base SHALL be 25 bits wide so that it can pass KEY_MAX without wrapping. When next_base > KEY_MAX, no further grants are issued -> DRAIN.
REQ-024 outstanding SHALL increment per grant and decrement per core_done bit. Simultaneous grant and done SHALL net to zero change. Multiple done bits in one cycle SHALL all be counted.
REQ-025 DRAIN with outstanding==0 and no core_found -> DONE_FAIL; failed=1.
REQ-026 Any core_found bit in DISPATCH or DRAIN -> DONE_OK next cycle: secret_key = key of lowest-index found core, cracked=1, core_abort pulses once.
REQ-027 A core_found in the same cycle as a core_done or as the last outstanding completion: found SHALL win.
REQ-028 core_found/core_done in IDLE, DONE_OK or DONE_FAIL SHALL be ignored.
REQ-029 A chunk's final key SHALL be clipped to KEY_MAX by the cores; the scheduler still grants the partial chunk.

Reset
REQ-030 reset SHALL force IDLE, all outputs 0, next_base=0, outstanding=0, rr pointer=0, immediately, including mid-search.
REQ-031 After reset deasserts, no grant SHALL issue until start.

Structure
REQ-032 Package crack_sched_pkg SHALL hold the state enum, KEY_W=24, and the outstanding-counter width function.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (req, mask, pointer in; one-hot grant out).

Verification
REQ-034 CHUNK_LOG2=20, 4 cores requesting continuously, all done, no found -> grants of bases 0,100000,200000,300000 hex to cores 0,1,2,3; failed=1 after the 4th done.
REQ-035 Core 2 pulses found with key 24'h1A2B3C during DISPATCH -> secret_key=1A2B3C, cracked=1, single core_abort, no further grants.
REQ-036 Cores 1 and 3 both pulse found, with keys 000111 and 000333, in the same cycle -> secret_key=000111.
REQ-037 Last outstanding done and a found on core 0 in the same cycle -> DONE_OK, failed stays 0.
REQ-038 reset asserted mid-DISPATCH with outstanding=3 -> all outputs 0 the same cycle; start then restarts with grant_base=0.
REQ-039 start pulsed while busy -> next_base and outstanding unaffected.
